// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character-LCD sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_SETUP = 3'd1,
        ST_EN_HI = 3'd2,
        ST_HOLD  = 3'd3,
        ST_EXEC  = 3'd4,
        ST_IDLE  = 3'd5
    } lcd_state_e;

    // Power-up init sequence, all sent with rs=0; entry 0 is the rightmost byte.
    localparam int INIT_CNT = 6;
    localparam logic [INIT_CNT-1:0][7:0] INIT_ROM = {
        8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
    };

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear and both home encodings (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter: holds at zero, zero_o flags the final cycle of a state.
module lcd_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Character-LCD sequencer: runs the power-up init sequence, then sends one
// byte per valid/ready handshake with setup, enable, hold and execution waits.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP   = 750000,
    parameter int T_SETUP     = 4,
    parameter int T_EN        = 12,
    parameter int T_HOLD      = 4,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 80000,
    parameter int INIT_EN     = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_rs_i,
    input  logic [7:0] req_data_i,
    input  logic       lcd_on_i,
    output logic       busy_o,
    output logic       init_done_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic       lcd_on_o
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EN, T_HOLD)),
                                max2(T_EXEC, T_EXEC_LONG));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    localparam lcd_state_e       RST_STATE = (INIT_EN != 0) ? ST_PWRUP : ST_IDLE;
    localparam logic [CNT_W-1:0] TMR_RST   = (INIT_EN != 0) ? CNT_W'(T_POWERUP - 1) : '0;
    localparam logic             DONE_RST  = (INIT_EN == 0);
    localparam logic [2:0]       INIT_END  = 3'(INIT_CNT);

    // A zero-length state would break the one-cycle-per-count timing.
    if (T_POWERUP < 1 || T_SETUP < 1 || T_EN < 1 || T_HOLD < 1 ||
        T_EXEC < 1 || T_EXEC_LONG < 1) begin : g_bad_timing
        $error("lcd_ctrl: every T_* parameter must be at least 1");
    end

    lcd_state_e       state_q, state_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic [2:0]       idx_q, idx_d;
    logic             done_q, done_d;
    logic             on_q, on_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    lcd_timer #(
        .W       (CNT_W),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    // State and datapath registers; reset drops EN at once via the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RST_STATE;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            idx_q   <= 3'd0;
            done_q  <= DONE_RST;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            on_q    <= on_d;
        end
    end

    // Next-state logic: each timed state leaves on the cycle its counter hits zero.
    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        data_d  = data_q;
        idx_d   = idx_q;
        done_d  = done_q;
        on_d    = lcd_on_i;
        unique case (state_q)
            ST_PWRUP: if (tmr_zero) begin
                rs_d    = 1'b0;
                data_d  = INIT_ROM[0];
                idx_d   = 3'd1;
                state_d = ST_SETUP;
            end
            ST_IDLE: if (req_valid_i) begin
                rs_d    = req_rs_i;
                data_d  = req_data_i;
                state_d = ST_SETUP;
            end
            ST_SETUP: if (tmr_zero) state_d = ST_EN_HI;
            ST_EN_HI: if (tmr_zero) state_d = ST_HOLD;
            ST_HOLD:  if (tmr_zero) state_d = ST_EXEC;
            ST_EXEC: if (tmr_zero) begin
                if (!done_q && idx_q != INIT_END) begin
                    rs_d    = 1'b0;
                    data_d  = INIT_ROM[idx_q];
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_SETUP;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // Reload the timer with the duration of whichever state is being entered.
    always_comb begin
        tmr_load  = (state_d != state_q);
        tmr_value = '0;
        case (state_d)
            ST_PWRUP: tmr_value = CNT_W'(T_POWERUP - 1);
            ST_SETUP: tmr_value = CNT_W'(T_SETUP - 1);
            ST_EN_HI: tmr_value = CNT_W'(T_EN - 1);
            ST_HOLD:  tmr_value = CNT_W'(T_HOLD - 1);
            ST_EXEC:  tmr_value = is_long_cmd(rs_q, data_q) ? CNT_W'(T_EXEC_LONG - 1)
                                                            : CNT_W'(T_EXEC - 1);
            default:  tmr_value = '0;
        endcase
    end

    // Outputs decoded from state; RS/DB hold the last byte sent.
    always_comb begin
        req_ready_o = (state_q == ST_IDLE);
        busy_o      = (state_q != ST_IDLE);
        lcd_en_o    = (state_q == ST_EN_HI);
        lcd_rs_o    = rs_q;
        lcd_data_o  = data_q;
        lcd_rw_o    = 1'b0;
        lcd_on_o    = on_q;
        init_done_o = done_q;
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Randomized bench for lcd_ctrl against a timeline model of the LCD sequencer.
module tb_lcd_ctrl;

    localparam int T_PU  = 20;
    localparam int T_SU  = 2;
    localparam int T_ENP = 4;
    localparam int T_HO  = 2;
    localparam int T_EX  = 10;
    localparam int T_EXL = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, rs, on_i;
    logic [7:0] data;
    logic       valid0;

    logic       ready, busy, done, lcd_rs, lcd_rw, lcd_en, lcd_on;
    logic [7:0] lcd_data;
    logic       ready0, busy0, done0, lcd_rs0, lcd_rw0, lcd_en0, lcd_on0;
    logic [7:0] lcd_data0;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_POWERUP(T_PU), .T_SETUP(T_SU), .T_EN(T_ENP), .T_HOLD(T_HO),
        .T_EXEC(T_EX), .T_EXEC_LONG(T_EXL), .INIT_EN(1)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(ready),
        .req_rs_i(rs), .req_data_i(data), .lcd_on_i(on_i), .busy_o(busy),
        .init_done_o(done), .lcd_data_o(lcd_data), .lcd_rs_o(lcd_rs),
        .lcd_rw_o(lcd_rw), .lcd_en_o(lcd_en), .lcd_on_o(lcd_on)
    );

    lcd_ctrl #(
        .T_POWERUP(T_PU), .T_SETUP(T_SU), .T_EN(T_ENP), .T_HOLD(T_HO),
        .T_EXEC(T_EX), .T_EXEC_LONG(T_EXL), .INIT_EN(0)
    ) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid0), .req_ready_o(ready0),
        .req_rs_i(rs), .req_data_i(data), .lcd_on_i(on_i), .busy_o(busy0),
        .init_done_o(done0), .lcd_data_o(lcd_data0), .lcd_rs_o(lcd_rs0),
        .lcd_rw_o(lcd_rw0), .lcd_en_o(lcd_en0), .lcd_on_o(lcd_on0)
    );

    typedef struct {
        logic       rs;
        logic [7:0] d;
        int         rise;
    } pulse_t;

    pulse_t     exp_q[$];
    logic [7:0] init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc, next_free, rise_at;
    bit         ready_m, done_m, en_prev, on_at_edge;
    logic       rs_at, last_rs;
    logic [7:0] d_at, last_d;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int exec_len(input logic r, input logic [7:0] d);
        return (!r && d >= 8'h01 && d <= 8'h03) ? T_EXL : T_EX;
    endfunction

    function automatic int xfer_len(input logic r, input logic [7:0] d);
        return T_SU + T_ENP + T_HO + exec_len(r, d);
    endfunction

    // Expected timeline after reset release: PWRUP, then the init bytes back to back.
    task automatic start_init_model();
        int t;
        exp_q.delete();
        t = T_PU;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{1'b0, init_seq[i], t + T_SU});
            t += xfer_len(1'b0, init_seq[i]);
        end
        next_free  = t;
        ready_m    = 1'b0;
        done_m     = 1'b0;
        en_prev    = 1'b0;
        on_at_edge = 1'b0;
        cyc        = 0;
    endtask

    task automatic step();
        check("lcd_on_delay", int'(lcd_on), int'(on_at_edge));
        check("lcd_on_delay0", int'(lcd_on0), int'(on_at_edge));
        @(posedge clk);
        cyc++;
        @(negedge clk);
        on_at_edge = on_i;
        if (ready_m && valid) begin
            exp_q.push_back('{rs, data, cyc + T_SU});
            next_free = cyc + xfer_len(rs, data);
            last_d    = data;
            last_rs   = rs;
        end
        ready_m = (cyc >= next_free);
        if (ready_m) done_m = 1'b1;
        check("ready", int'(ready), int'(ready_m));
        check("busy", int'(busy), int'(!ready_m));
        check("init_done", int'(done), int'(done_m));
        check("rw", int'(lcd_rw), 0);
        check("ready0", int'(ready0), 1);
        check("init_done0", int'(done0), 1);
        check("en0", int'(lcd_en0), 0);
        if (lcd_en && !en_prev) begin
            rise_at = cyc;
            rs_at   = lcd_rs;
            d_at    = lcd_data;
        end
        if (!lcd_en && en_prev) begin
            check("pulse_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                pulse_t p;
                p = exp_q.pop_front();
                check("en_rise", rise_at, p.rise);
                check("en_width", cyc - rise_at, T_ENP);
                check("pulse_rs", int'(rs_at), int'(p.rs));
                check("pulse_data", int'(d_at), int'(p.d));
                check("hold_data", int'(lcd_data), int'(p.d));
            end
        end
        en_prev = lcd_en;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 200 && !ready_m; i++) step();
        check("ready_timeout", int'(ready_m), 1);
    endtask

    task automatic send(input logic r, input logic [7:0] d);
        wait_ready();
        valid = 1'b1;
        rs    = r;
        data  = d;
        step();
        valid = 1'b0;
        data  = 8'($urandom);
        rs    = 1'($urandom);
    endtask

    function automatic logic [7:0] pick();
        if ($urandom_range(0, 3) == 0) return 8'($urandom_range(1, 3));
        return 8'($urandom);
    endfunction

    initial begin
        rst_n  = 1'b0;
        valid  = 1'b0;
        valid0 = 1'b0;
        rs     = 1'b0;
        data   = 8'h00;
        on_i   = 1'b0;
        last_d = 8'h00;
        last_rs = 1'b0;
        cyc    = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_en", int'(lcd_en), 0);
        check("rst_rs", int'(lcd_rs), 0);
        check("rst_data", int'(lcd_data), 0);
        check("rst_on", int'(lcd_on), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(ready), 0);
        rst_n = 1'b1;
        start_init_model();
        repeat (175) step();

        // Directed bytes, including the long/short execution boundaries.
        send(1'b1, 8'h41);
        send(1'b0, 8'h01);
        send(1'b0, 8'h80);
        send(1'b1, 8'h01);
        send(1'b0, 8'h02);
        send(1'b0, 8'h03);
        send(1'b0, 8'h04);
        wait_ready();

        // Valid held high, data changing every cycle.
        valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            data = pick();
            rs   = 1'($urandom);
            on_i = 1'($urandom);
            step();
        end

        // Sparse random requests.
        for (int i = 0; i < 1500; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            data  = pick();
            rs    = 1'($urandom);
            on_i  = 1'($urandom);
            step();
        end
        valid = 1'b0;
        repeat (100) step();
        check("all_pulses_sent", exp_q.size(), 0);
        check("idle_data", int'(lcd_data), int'(last_d));
        check("idle_rs", int'(lcd_rs), int'(last_rs));

        // Reset in the middle of an enable pulse.
        send(1'b0, 8'h80);
        for (int i = 0; i < 40 && !lcd_en; i++) step();
        check("en_seen", int'(lcd_en), 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_en", int'(lcd_en), 0);
        check("async_ready", int'(ready), 0);
        check("async_done", int'(done), 0);
        repeat (2) @(negedge clk);
        on_i  = 1'b0;
        rst_n = 1'b1;
        start_init_model();
        repeat (175) step();
        check("reinit_pulses", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
